// File: rtl/wbk_ctrl_if.sv
// Handshake bundle between the write-back sequencer, the object
// processor sequencer, the arithmetic unit and the bus write port.
interface wbk_ctrl_if;
    logic       wbreq;
    logic       scaled;
    logic       wbkdone;
    logic       heightnz;
    logic       memack;
    logic       wbkstart;
    logic       memwr;
    logic [1:0] wrsel;
    logic       wback;
    logic       expire;
    logic       busy;
    logic       tmo;

    modport master (
        output wbreq, scaled, wbkdone, heightnz, memack,
        input  wbkstart, memwr, wrsel, wback, expire, busy, tmo
    );

    modport slave (
        input  wbreq, scaled, wbkdone, heightnz, memack,
        output wbkstart, memwr, wrsel, wback, expire, busy, tmo
    );
endinterface

// File: rtl/wbk_ctrl.sv
// Object-processor write-back sequencer: start arithmetic, wait,
// write phrase 0 (and phrase 2 for scaled objects), acknowledge.
module wbk_ctrl #(
    parameter int WB_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    wbk_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE, START, CALC, WR0, WR2, DONE
    } state_t;

    localparam logic [7:0] LAST = 8'(WB_TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       scl_r;
    logic       hnz_r;
    logic       tmo_r;
    logic       start_r;
    logic       memwr_r;
    logic [1:0] wrsel_r;
    logic       wback_r;
    logic       expire_r;
    logic       busy_r;

    assign bus.wbkstart = start_r;
    assign bus.memwr    = memwr_r;
    assign bus.wrsel    = wrsel_r;
    assign bus.wback    = wback_r;
    assign bus.expire   = expire_r;
    assign bus.busy     = busy_r;
    assign bus.tmo      = tmo_r;

    // Sequencer; outputs are registered alongside the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            scl_r    <= 1'b0;
            hnz_r    <= 1'b0;
            tmo_r    <= 1'b0;
            start_r  <= 1'b0;
            memwr_r  <= 1'b0;
            wrsel_r  <= 2'd0;
            wback_r  <= 1'b0;
            expire_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            start_r  <= 1'b0;
            wback_r  <= 1'b0;
            expire_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.wbreq) begin
                        scl_r   <= bus.scaled;
                        tmo_r   <= 1'b0;
                        cnt     <= '0;
                        state   <= START;
                        start_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                START: begin
                    state <= CALC;
                end
                CALC: begin
                    cnt <= cnt + 8'd1;
                    if (bus.wbkdone) begin
                        hnz_r <= bus.heightnz;
                        if (bus.heightnz) begin
                            state   <= WR0;
                            memwr_r <= 1'b1;
                            wrsel_r <= 2'd0;
                        end else begin
                            state    <= DONE;
                            wback_r  <= 1'b1;
                            expire_r <= 1'b1;
                        end
                    end else if (cnt == LAST) begin
                        tmo_r   <= 1'b1;
                        hnz_r   <= 1'b1;
                        state   <= DONE;
                        wback_r <= 1'b1;
                    end
                end
                WR0: begin
                    if (bus.memack) begin
                        if (scl_r) begin
                            state   <= WR2;
                            wrsel_r <= 2'd2;
                        end else begin
                            state    <= DONE;
                            memwr_r  <= 1'b0;
                            wrsel_r  <= 2'd0;
                            wback_r  <= 1'b1;
                            expire_r <= !hnz_r;
                        end
                    end
                end
                WR2: begin
                    if (bus.memack) begin
                        state    <= DONE;
                        memwr_r  <= 1'b0;
                        wrsel_r  <= 2'd0;
                        wback_r  <= 1'b1;
                        expire_r <= !hnz_r;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wbk_ctrl.sv
// Randomized bench for wbk_ctrl: each request is planned as a set of
// event times and the expected output trace is derived from that plan.
module tb_wbk_ctrl;
    localparam int T = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    wbk_ctrl_if bus ();

    wbk_ctrl #(.WB_TIMEOUT(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int  nvec = 0;
    int  nerr = 0;
    bit  tmo_m = 1'b0;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%b exp=%b (st,wr,sel[2],wb,ex,bz,tmo)",
                     tag, got, exp);
        end
    endtask

    function automatic logic [7:0] obs();
        return {bus.wbkstart, bus.memwr, bus.wrsel,
                bus.wback, bus.expire, bus.busy, bus.tmo};
    endfunction

    function automatic logic [7:0] pk(bit st, bit mw, bit [1:0] ws,
                                      bit wb, bit ex, bit bz, bit tm);
        return {st, mw, ws, wb, ex, bz, tm};
    endfunction

    task automatic noise();
        bus.wbkdone  = 1'($urandom);
        bus.heightnz = 1'($urandom);
        bus.memack   = 1'($urandom);
        bus.scaled   = 1'($urandom);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.wbreq = 1'b0;
            noise();
            @(negedge clk);
            chk(tag, obs(), pk(0, 0, 2'd0, 0, 0, 0, tmo_m));
        end
    endtask

    // d: CALC cycle index of wbkdone (>= T means timeout)
    // a0/a2: cycles of stall before memack on each write
    // rst_at: cycle at which to abort with reset (-1 = none)
    task automatic run_txn(input int d, input bit scl, input bit hnz,
                           input int a0, input int a2,
                           input int rst_at, input string tag);
        int  c, last, w0s, w0e, w2s, done;
        bit  to, w;
        bit  st, mw, wb, ex, tm;
        bit [1:0] ws;
        to   = (d >= T);
        c    = to ? T - 1 : d;
        last = 2 + c;
        w    = !to && hnz;
        w0s  = last + 1;
        w0e  = w0s + a0;
        w2s  = w0e + 1;
        if (!w)
            done = last + 1;
        else if (scl)
            done = w2s + a2 + 1;
        else
            done = w0e + 1;
        for (int k = 0; k <= done; k++) begin
            @(posedge clk);
            #1;
            noise();
            bus.wbreq = (k == 0) || ($urandom_range(3) == 0);
            if (k == 0)
                bus.scaled = scl;
            if (k >= 2 && k <= last)
                bus.wbkdone = (k == 2 + d);
            if (k == 2 + d)
                bus.heightnz = hnz;
            if (w && k >= w0s && k <= w0e)
                bus.memack = (k == w0e);
            if (w && scl && k >= w2s && k < done)
                bus.memack = (k == done - 1);
            @(negedge clk);
            st = (k == 1);
            mw = w && k >= w0s && k < done;
            ws = (w && scl && k >= w2s && k < done) ? 2'd2 : 2'd0;
            wb = (k == done);
            ex = wb && !to && !hnz;
            tm = (k == 0) ? tmo_m : (to && k == done);
            chk(tag, obs(), pk(st, mw, ws, wb, ex, k >= 1, tm));
            if (k == rst_at) begin
                #2;
                reset = 1'b1;
                #1;
                chk({tag, "_async_rst"}, obs(), 8'd0);
                @(posedge clk);
                #1;
                reset = 1'b0;
                tmo_m = 1'b0;
                return;
            end
        end
        tmo_m = to;
    endtask

    initial begin
        reset        = 1'b1;
        bus.wbreq    = 1'b0;
        bus.scaled   = 1'b0;
        bus.wbkdone  = 1'b0;
        bus.heightnz = 1'b0;
        bus.memack   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", obs(), 8'd0);
        reset = 1'b0;
        idle(2, "idle0");

        run_txn(2, 1'b0, 1'b1, 0, 0, -1, "unscaled");
        run_txn(0, 1'b1, 1'b1, 3, 3, -1, "scaled_stall");
        run_txn(0, 1'b1, 1'b0, 0, 0, -1, "zero_height");
        run_txn(9, 1'b0, 1'b1, 0, 0, -1, "timeout");
        idle(1, "tmo_sticky");
        run_txn(1, 1'b0, 1'b1, 1, 0, -1, "tmo_clear");
        run_txn(T - 1, 1'b0, 1'b1, 0, 0, -1, "done_at_limit");
        run_txn(0, 1'b1, 1'b1, 0, 3, 6, "abort_wr2");
        idle(4, "after_abort");
        run_txn(1, 1'b1, 1'b1, 1, 1, -1, "fresh");

        for (int i = 0; i < 150; i++) begin
            run_txn($urandom_range(T + 2), 1'($urandom),
                    ($urandom_range(3) != 0),
                    $urandom_range(3), $urandom_range(3), -1, "rand");
            idle($urandom_range(2), "rand_gap");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
